// File: rtl/mma_pkg.sv
// Shared sizing and FSM encoding for the 2x2 matrix result collector.
package mma_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned N_RESULTS = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

endpackage

// File: rtl/mma_result_buf.sv
// Result storage: one synchronous write port, one combinational read port, no reset.
module mma_result_buf #(
  parameter int unsigned DATA_W    = mma_pkg::DATA_W,
  parameter int unsigned N_RESULTS = mma_pkg::N_RESULTS,
  parameter int unsigned PTR_W     = (N_RESULTS > 1) ? $clog2(N_RESULTS) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [N_RESULTS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mac_result_collector.sv
// Collects N_RESULTS MAC results per matrix, then drains them row-major over a valid/ready port.
module mac_result_collector #(
  parameter int unsigned DATA_W    = mma_pkg::DATA_W,
  parameter int unsigned N_RESULTS = mma_pkg::N_RESULTS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] mac_output,
  input  logic              mac_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_index,
  output logic              out_last,
  output logic              matrix_done,
  output logic              overflow
);
  import mma_pkg::*;

  localparam int unsigned PTR_W = (N_RESULTS > 1) ? $clog2(N_RESULTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_RESULTS - 1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              matrix_done_q, matrix_done_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [1:0]        out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;

  mma_result_buf #(
    .DATA_W    (DATA_W),
    .N_RESULTS (N_RESULTS),
    .PTR_W     (PTR_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_cnt_q),
    .wdata_i (mac_output),
    .raddr_i (rd_ptr_d),
    .rdata_o (buf_rdata)
  );

  // State register and registered output port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= COLLECT;
      wr_cnt_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      matrix_done_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_index_q   <= '0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      matrix_done_q <= matrix_done_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_index_q   <= out_index_d;
      out_data_q    <= out_data_d;
    end
  end

  // Next-state logic; clear overrides everything, including buffer writes.
  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    overflow_d    = overflow_q;
    matrix_done_d = 1'b0;
    buf_we        = 1'b0;

    if (clear) begin
      state_d    = COLLECT;
      wr_cnt_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (mac_valid && enable) begin
            buf_we = 1'b1;
            if (wr_cnt_q == LAST_PTR) begin
              state_d       = DRAIN;
              wr_cnt_d      = '0;
              rd_ptr_d      = '0;
              matrix_done_d = 1'b1;
            end else begin
              wr_cnt_d = wr_cnt_q + PTR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (mac_valid) begin
            overflow_d = 1'b1;
          end
          if (out_ready) begin
            if (rd_ptr_q == LAST_PTR) begin
              state_d  = COLLECT;
              rd_ptr_d = '0;
            end else begin
              rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // Output port is precomputed from the next state; a same-cycle write to the read slot is forwarded.
  always_comb begin
    out_valid_d = (state_d == DRAIN);
    out_index_d = 2'(rd_ptr_d);
    out_last_d  = out_valid_d && (rd_ptr_d == LAST_PTR);
    out_data_d  = '0;
    if (out_valid_d) begin
      out_data_d = (buf_we && (wr_cnt_q == rd_ptr_d)) ? mac_output : buf_rdata;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;
  assign out_last    = out_last_q;
  assign matrix_done = matrix_done_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_mac_result_collector.sv
// Scoreboard bench for mac_result_collector: directed matrices, stall, overflow, gating, reset.
module tb_mac_result_collector;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [15:0] mac_output;
  logic        mac_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_index;
  logic        out_last;
  logic        matrix_done;
  logic        overflow;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   md_count = 0;

  mac_result_collector dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .mac_output  (mac_output),
    .mac_valid   (mac_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_last    (out_last),
    .matrix_done (matrix_done),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (reset && matrix_done) md_count++;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got data 0x%0h idx %0d, expected none", out_data, out_index);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("beat_data", 32'(out_data), 32'(e.data));
        chk("beat_index", 32'(out_index), 32'(e.idx));
        chk("beat_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  task automatic expect4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    exp_t e;
    e.data = a; e.idx = 2'd0; e.last = 1'b0; sb.push_back(e);
    e.data = b; e.idx = 2'd1; e.last = 1'b0; sb.push_back(e);
    e.data = c; e.idx = 2'd2; e.last = 1'b0; sb.push_back(e);
    e.data = d; e.idx = 2'd3; e.last = 1'b1; sb.push_back(e);
  endtask

  // Called at posedge+1; holds mac_valid for exactly one rising edge.
  task automatic mac_push(input logic [15:0] v);
    mac_output = v;
    mac_valid  = 1'b1;
    @(posedge clk); #1;
    mac_valid  = 1'b0;
    mac_output = '0;
  endtask

  task automatic push4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    mac_push(a); mac_push(b); mac_push(c); mac_push(d);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int md_base;
    reset = 1'b0; enable = 1'b0; clear = 1'b0;
    mac_output = '0; mac_valid = 1'b0; out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_matrix_done", 32'(matrix_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Nominal matrix with out_ready held high.
    enable = 1'b1; out_ready = 1'b1;
    md_base = md_count;
    expect4(16'd13, 16'd16, 16'd29, 16'd36);
    push4(16'd13, 16'd16, 16'd29, 16'd36);
    chk("nom_first_valid", 32'(out_valid), 32'd1);
    chk("nom_first_data", 32'(out_data), 32'd13);
    wait_drain("nom_drain_done");
    chk("nom_matrix_done_once", 32'(md_count - md_base), 32'd1);
    chk("nom_back_collect", 32'(out_valid), 32'd0);
    chk("nom_collect_data", 32'(out_data), 32'd0);

    // Backpressure: stall 3 cycles while result 16 is presented.
    expect4(16'd13, 16'd16, 16'd29, 16'd36);
    push4(16'd13, 16'd16, 16'd29, 16'd36);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'd16);
      chk("stall_index", 32'(out_index), 32'd1);
      chk("stall_last", 32'(out_last), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain("stall_drain_done");

    // Overflow: a result arriving during DRAIN is dropped and flagged.
    expect4(16'd13, 16'd16, 16'd29, 16'd36);
    push4(16'd13, 16'd16, 16'd29, 16'd36);
    mac_push(16'h00FF);
    chk("ovf_set", 32'(overflow), 32'd1);
    wait_drain("ovf_drain_done");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Gating: pulses with enable low must be ignored entirely.
    enable = 1'b0;
    md_base = md_count;
    for (int i = 0; i < 5; i++) mac_push(16'(100 + i));
    repeat (2) @(posedge clk);
    #1;
    chk("gate_no_valid", 32'(out_valid), 32'd0);
    chk("gate_no_done", 32'(md_count - md_base), 32'd0);
    chk("gate_no_ovf", 32'(overflow), 32'd0);
    enable = 1'b1;
    expect4(16'hAAAA, 16'h8001, 16'h7FFF, 16'hFFFF);
    push4(16'hAAAA, 16'h8001, 16'h7FFF, 16'hFFFF);
    wait_drain("gate_drain_done");

    // Reset mid-drain: after 13 transfers, reset drops out_valid at once.
    out_ready = 1'b0;
    expect4(16'd13, 16'd16, 16'd29, 16'd36);
    push4(16'd13, 16'd16, 16'd29, 16'd36);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    sb.delete();
    chk("mid_before_rst_data", 32'(out_data), 32'd16);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_index", 32'(out_index), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    expect4(16'd1, 16'd2, 16'd3, 16'd4);
    push4(16'd1, 16'd2, 16'd3, 16'd4);
    wait_drain("post_rst_drain_done");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_result_collector.md
MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of MAC results and out_data.
REQ-002 Parameter N_RESULTS, default 4, SHALL set the results per matrix (2x2 product, row-major C00,C01,C10,C11).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 enable  input  1  SHALL gate result capture in COLLECT.
REQ-006 clear  input  1  SHALL be a synchronous abort/flush.
REQ-007 mac_output  input  DATA_W  SHALL carry one finished dot-product result.
REQ-008 mac_valid  input  1  SHALL qualify mac_output for exactly one cycle per result.
REQ-009 out_data  output  DATA_W  SHALL carry the buffered result selected by the read pointer.
REQ-010 out_valid  output  1  SHALL indicate that out_data is presentable.
REQ-011 out_ready  input  1  SHALL be the downstream acceptance signal.
REQ-012 out_index  output  2  SHALL give the row-major position of out_data.
REQ-013 out_last  output  1  SHALL be high with out_valid when out_index = N_RESULTS-1.
REQ-014 matrix_done  output  1  SHALL pulse for one cycle when the final result of a matrix is captured.
REQ-015 overflow  output  1  SHALL be a sticky dropped-result flag.

Function
REQ-016 The FSM SHALL have two states, COLLECT and DRAIN, with wr_cnt and rd_ptr counters, each 0..N_RESULTS-1.
REQ-017 COLLECT behaviour:
- Capture condition: mac_valid and enable sampled high at a rising edge.
- On capture: store mac_output in buf[wr_cnt] and increment wr_cnt.
- mac_valid with enable low: ignored; no capture, no overflow.
REQ-018 On capture with wr_cnt = N_RESULTS-1:
- pulse matrix_done in the following cycle;
- enter DRAIN in the following cycle with rd_ptr = 0 and wr_cnt = 0.
REQ-019 out_valid SHALL be high exactly when the state is DRAIN, so the first result is presented 1 cycle after the final capture.
REQ-020 Transfer SHALL occur when out_valid and out_ready are both high; each transfer increments rd_ptr.
REQ-021 While out_valid is high and out_ready is low, out_data, out_index and out_last SHALL hold stable.
REQ-022 A transfer with out_last high SHALL return the FSM to COLLECT in the next cycle.
REQ-023 Any mac_valid sampled high in DRAIN SHALL be dropped and SHALL set overflow, including in the cycle of the final transfer. Drops are independent of enable.
REQ-024 Out-of-state outputs:
- out_data SHALL be 0 in COLLECT;
- out_index SHALL equal rd_ptr;
- out_valid SHALL not depend combinationally on out_ready.
REQ-025 clear SHALL:
- take priority over all other inputs;
- next cycle, force COLLECT, wr_cnt = 0, rd_ptr = 0, overflow = 0, matrix_done = 0;
- leave buffer contents unchanged (they are don't-care).
REQ-026 Results SHALL be stored unmodified at DATA_W bits, with no truncation or sign change.

Reset
REQ-027 While reset is low, the block SHALL hold:
- state COLLECT;
- wr_cnt = 0 and rd_ptr = 0;
- out_valid, out_last, matrix_done, overflow = 0;
- out_index = 0 and out_data = 0.
REQ-028 Reset asserted mid-DRAIN SHALL abort the drain immediately (out_valid low asynchronously); results not yet transferred SHALL be lost.
REQ-029 After reset deasserts, the first capture SHALL occur no earlier than the first rising edge at which reset is high.

Structure
REQ-030 DATA_W, N_RESULTS and the COLLECT/DRAIN state encoding SHALL reside in shared package mma_pkg.
REQ-031 The N_RESULTS x DATA_W storage SHALL be sub-module mma_result_buf:
- one write port (we, waddr, wdata);
- one combinational read port (raddr, rdata);
- no reset on the storage.

Verification
REQ-032 Nominal: A={1,2,3,4}, B={3,4,5,6}; upstream MAC emits 13,16,29,36 with out_ready held high ->
- matrix_done pulses once;
- out_data sequence 13,16,29,36 with out_index 0..3;
- out_last high on 36 only;
- back in COLLECT the cycle after.
REQ-033 Backpressure: same data, out_ready low for 3 cycles while 16 is presented -> out_data holds 16 and out_index holds 1 across the stall; no result lost or duplicated.
REQ-034 Overflow: mac_valid with mac_output=0x00FF during DRAIN -> overflow goes high and stays high; drained sequence unchanged; clear then returns overflow to 0.
REQ-035 Gating: mac_valid pulses with enable=0 -> no capture, wr_cnt stays 0, no matrix_done, overflow stays 0.
REQ-036 Reset mid-drain: reset low after result 13 transfers -> out_valid drops immediately. After release, a fresh set 1,2,3,4 drains as 1,2,3,4 with out_index 0..3.
